// File: rtl/memory_stage.sv
// Memory stage of the 5-stage pipeline: owns the 16-bit data/stack memory and
// performs loads, stores, flag push/pop and two-cycle 32-bit PC push/pop.
module memory_stage #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        In_Valid,
    input  logic        MR,
    input  logic        MW,
    input  logic        WB,
    input  logic        JWSP,
    input  logic        Stack_PC,
    input  logic        Stack_Flags,
    input  logic [2:0]  WB_Address,
    input  logic [31:0] Data,
    input  logic [31:0] Address,
    input  logic [2:0]  Final_Flags,
    output logic        Stall,
    output logic        Out_Valid,
    output logic        WB_Out,
    output logic [2:0]  WB_Address_Out,
    output logic        JWSP_Out,
    output logic [15:0] Result,
    output logic [2:0]  Flags_From_Memory,
    output logic        Flags_Valid,
    output logic [31:0] PC_From_Stack,
    output logic        PC_Valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PUSH2 = 2'd1;
    localparam logic [1:0] POP2  = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] lo_hold;

    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] a_inc;
    logic [ADDR_WIDTH-1:0] a_dec;
    logic [DATA_WIDTH-1:0] rd_lo;
    logic [DATA_WIDTH-1:0] rd_hi;

    logic                  do_write;
    logic                  do_read;
    logic                  flag_op;
    logic                  pc_start;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Only the low address bits index the memory.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^Address[31:ADDR_WIDTH];

    assign a     = Address[ADDR_WIDTH-1:0];
    assign a_inc = a + ADDR_WIDTH'(1);
    assign a_dec = a - ADDR_WIDTH'(1);
    assign rd_lo = mem[a];
    assign rd_hi = mem[a_inc];

    // Write has priority over read; PC transfer has priority over flags.
    assign do_write = In_Valid & MW;
    assign do_read  = In_Valid & MR & ~MW;
    assign flag_op  = Stack_Flags & ~Stack_PC;
    assign pc_start = (state == IDLE) & (do_write | do_read) & Stack_PC;
    assign Stall    = pc_start & ~rst;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        wr_en   = 1'b0;
        wr_addr = a;
        wr_data = Data[DATA_WIDTH-1:0];
        if (!rst) begin
            if (state == PUSH2) begin
                wr_en   = 1'b1;
                wr_addr = a_dec;
            end else if (state == IDLE && do_write) begin
                wr_en = 1'b1;
                if (Stack_PC)
                    wr_data = Data[31:16];
                else if (Stack_Flags)
                    wr_data = {{(DATA_WIDTH-3){1'b0}}, Final_Flags};
            end
        end
    end

    // NOTE: the memory array has no reset; only its write port is clocked.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            lo_hold           <= '0;
            Out_Valid         <= 1'b0;
            WB_Out            <= 1'b0;
            WB_Address_Out    <= '0;
            JWSP_Out          <= 1'b0;
            Result            <= '0;
            Flags_From_Memory <= '0;
            Flags_Valid       <= 1'b0;
            PC_From_Stack     <= '0;
            PC_Valid          <= 1'b0;
        end else begin
            Flags_Valid <= 1'b0;
            PC_Valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!In_Valid || pc_start) begin
                        // Bubble, or first half of a two-cycle PC transfer.
                        Out_Valid <= 1'b0;
                        WB_Out    <= 1'b0;
                        if (pc_start) begin
                            if (do_write) begin
                                state <= PUSH2;
                            end else begin
                                lo_hold <= rd_lo;
                                state   <= POP2;
                            end
                        end
                    end else begin
                        Out_Valid      <= 1'b1;
                        WB_Out         <= WB;
                        WB_Address_Out <= WB_Address;
                        JWSP_Out       <= JWSP;
                        if (do_read) begin
                            Result <= rd_lo;
                            if (flag_op) begin
                                Flags_From_Memory <= rd_lo[2:0];
                                Flags_Valid       <= 1'b1;
                            end
                        end else begin
                            Result <= Data[15:0];
                        end
                    end
                end
                PUSH2, POP2: begin
                    Out_Valid      <= 1'b1;
                    WB_Out         <= WB;
                    WB_Address_Out <= WB_Address;
                    JWSP_Out       <= JWSP;
                    if (state == POP2) begin
                        PC_From_Stack <= {rd_hi, lo_hold};
                        PC_Valid      <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// operations checked against a word-array model of the stack/data memory.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_Valid, MR, MW, WB, JWSP, Stack_PC, Stack_Flags;
    logic [2:0]  WB_Address;
    logic [31:0] Data, Address;
    logic [2:0]  Final_Flags;
    logic        Stall, Out_Valid, WB_Out, JWSP_Out, Flags_Valid, PC_Valid;
    logic [2:0]  WB_Address_Out, Flags_From_Memory;
    logic [15:0] Result;
    logic [31:0] PC_From_Stack;

    memory_stage #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .In_Valid(In_Valid), .MR(MR), .MW(MW), .WB(WB),
        .JWSP(JWSP), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
        .WB_Address(WB_Address), .Data(Data), .Address(Address),
        .Final_Flags(Final_Flags), .Stall(Stall), .Out_Valid(Out_Valid),
        .WB_Out(WB_Out), .WB_Address_Out(WB_Address_Out), .JWSP_Out(JWSP_Out),
        .Result(Result), .Flags_From_Memory(Flags_From_Memory),
        .Flags_Valid(Flags_Valid), .PC_From_Stack(PC_From_Stack), .PC_Valid(PC_Valid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] model_mem [4096];
    logic [2:0]  exp_flags;
    logic [31:0] exp_pc;

    task automatic drive(input logic v, mr, mw, wb, jw, spc, sfl,
                         input logic [2:0] wba, input logic [31:0] d,
                         input logic [31:0] addr, input logic [2:0] fl);
        In_Valid = v; MR = mr; MW = mw; WB = wb; JWSP = jw;
        Stack_PC = spc; Stack_Flags = sfl; WB_Address = wba;
        Data = d; Address = addr; Final_Flags = fl;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: push stores hi at A and lo at A-1 (modulo 4096).
    task automatic model_push(input logic [11:0] a, input logic [31:0] d);
        logic [11:0] am1;
        am1 = a - 12'd1;
        model_mem[a]   = d[31:16];
        model_mem[am1] = d[15:0];
    endtask

    function automatic logic [31:0] model_pop(input logic [11:0] a);
        logic [11:0] ap1;
        ap1 = a + 12'd1;
        return {model_mem[ap1], model_mem[a]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        #2;
        vectors++;
        if ({Stall, Out_Valid, WB_Out, WB_Address_Out, JWSP_Out, Result, Flags_From_Memory,
             Flags_Valid, PC_From_Stack, PC_Valid} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0", {Stall, Out_Valid, WB_Out, WB_Address_Out,
                     JWSP_Out, Result, Flags_From_Memory, Flags_Valid, PC_From_Stack, PC_Valid});
        end
        drive(1, 0, 1, 0, 0, 1, 0, 3'd0, 32'h1111_2222, 32'h0, 3'd0);
        #1;
        vectors++;
        if (Stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall got=%b exp=0", Stall);
        end
        tick();
        tick();
        @(negedge clk);
        idle_in();
        rst = 1'b0;
        exp_flags = 3'd0;
        exp_pc    = 32'd0;
        tick();
    endtask

    task automatic test_store_load();
        drive(1, 0, 1, 0, 0, 0, 0, 3'd0, 32'h0000_BEEF, 32'h20, 3'd0);
        model_mem[12'h020] = 16'hBEEF;
        tick();
        vectors++;
        if (Out_Valid !== 1'b1 || WB_Out !== 1'b0) begin
            miscompares++;
            $display("FAIL store_valid got=%b%b exp=10", Out_Valid, WB_Out);
        end
        drive(1, 1, 0, 1, 0, 0, 0, 3'd3, 32'd0, 32'h20, 3'd0);
        tick();
        vectors++;
        if ({Result, WB_Out, WB_Address_Out, Out_Valid} !== {16'hBEEF, 1'b1, 3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL load_fields got=%h/%b/%0d/%b exp=beef/1/3/1",
                     Result, WB_Out, WB_Address_Out, Out_Valid);
        end
    endtask

    task automatic test_pc_stack();
        logic [15:0] exp_words [2];
        logic [31:0] load_addr [2];
        exp_words = '{16'h1234, 16'h5678};
        load_addr = '{32'hFFF, 32'hFFE};
        drive(1, 0, 1, 0, 0, 1, 0, 3'd0, 32'h1234_5678, 32'h0FFF, 3'd0);
        model_push(12'hFFF, 32'h1234_5678);
        #1;
        vectors++;
        if (Stall !== 1'b1) begin miscompares++; $display("FAIL push_stall1 got=%b exp=1", Stall); end
        tick();
        vectors++;
        if (Stall !== 1'b0 || Out_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL push_stall2 got=stall%b valid%b exp=stall0 valid0", Stall, Out_Valid);
        end
        tick();
        vectors++;
        if (Out_Valid !== 1'b1) begin miscompares++; $display("FAIL push_retire got=%b exp=1", Out_Valid); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 3'd0, 32'd0, load_addr[i], 3'd0);
            tick();
            vectors++;
            if (Result !== exp_words[i]) begin
                miscompares++;
                $display("FAIL push_word%0d got=%h exp=%h", i, Result, exp_words[i]);
            end
        end
        drive(1, 1, 0, 0, 1, 1, 0, 3'd0, 32'd0, 32'h0FFE, 3'd0);
        #1;
        vectors++;
        if (Stall !== 1'b1) begin miscompares++; $display("FAIL pop_stall1 got=%b exp=1", Stall); end
        tick();
        vectors++;
        if (Stall !== 1'b0 || Out_Valid !== 1'b0 || PC_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_stall2 got=%b%b%b exp=000", Stall, Out_Valid, PC_Valid);
        end
        tick();
        exp_pc = 32'h1234_5678;
        vectors++;
        if ({PC_From_Stack, PC_Valid, Out_Valid, JWSP_Out} !== {exp_pc, 3'b111}) begin
            miscompares++;
            $display("FAIL pop_pc got=%h/%b%b%b exp=%h/111", PC_From_Stack, PC_Valid,
                     Out_Valid, JWSP_Out, exp_pc);
        end
        idle_in();
        tick();
        vectors++;
        if (PC_Valid !== 1'b0 || PC_From_Stack !== exp_pc) begin
            miscompares++;
            $display("FAIL pop_pulse got=%b/%h exp=0/%h", PC_Valid, PC_From_Stack, exp_pc);
        end
    endtask

    task automatic test_flags();
        drive(1, 0, 1, 0, 0, 0, 1, 3'd0, 32'hFFFF_FFFF, 32'h10, 3'b101);
        model_mem[12'h010] = 16'h0005;
        tick();
        drive(1, 1, 0, 0, 0, 0, 1, 3'd0, 32'd0, 32'h10, 3'd0);
        tick();
        exp_flags = 3'b101;
        vectors++;
        if ({Flags_From_Memory, Flags_Valid, Result} !== {exp_flags, 1'b1, 16'h0005}) begin
            miscompares++;
            $display("FAIL flag_pop got=%b/%b/%h exp=101/1/0005", Flags_From_Memory, Flags_Valid, Result);
        end
        idle_in();
        tick();
        vectors++;
        if (Flags_Valid !== 1'b0 || Flags_From_Memory !== exp_flags) begin
            miscompares++;
            $display("FAIL flag_pulse got=%b/%b exp=0/101", Flags_Valid, Flags_From_Memory);
        end
    endtask

    task automatic test_wrap();
        drive(1, 0, 1, 0, 0, 1, 0, 3'd0, 32'hA5A5_5A5A, 32'h0, 3'd0);
        model_push(12'h000, 32'hA5A5_5A5A);
        tick();
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'hFFF, 3'd0);
        tick();
        vectors++;
        if (Result !== model_mem[12'hFFF]) begin
            miscompares++;
            $display("FAIL wrap_lo got=%h exp=%h", Result, model_mem[12'hFFF]);
        end
        drive(1, 1, 0, 0, 0, 1, 0, 3'd0, 32'd0, 32'hFFF, 3'd0);
        tick();
        tick();
        exp_pc = model_pop(12'hFFF);
        vectors++;
        if (PC_From_Stack !== exp_pc || PC_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_pop got=%h/%b exp=%h/1", PC_From_Stack, PC_Valid, exp_pc);
        end
    endtask

    task automatic test_reset_mid_push();
        drive(1, 0, 1, 0, 0, 0, 0, 3'd0, 32'h0000_AAAA, 32'h3F, 3'd0);
        model_mem[12'h03F] = 16'hAAAA;
        tick();
        drive(1, 0, 1, 1, 1, 1, 0, 3'd5, 32'hCAFE_D00D, 32'h40, 3'd0);
        model_mem[12'h040] = 16'hCAFE;
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({Stall, Out_Valid, WB_Out, WB_Address_Out, JWSP_Out, Result, Flags_From_Memory,
             Flags_Valid, PC_From_Stack, PC_Valid} !== 64'd0) begin
            miscompares++;
            $display("FAIL midpush_reset got=%h exp=0", {Stall, Out_Valid, WB_Out, WB_Address_Out,
                     JWSP_Out, Result, Flags_From_Memory, Flags_Valid, PC_From_Stack, PC_Valid});
        end
        exp_flags = 3'd0;
        exp_pc    = 32'd0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 1, 0, 0, 0, 3'd1, 32'd0, 32'h3F, 3'd0);
        #1;
        vectors++;
        if (Stall !== 1'b0) begin miscompares++; $display("FAIL midpush_stall got=%b exp=0", Stall); end
        tick();
        vectors++;
        if (Result !== 16'hAAAA || Out_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midpush_lo got=%h/%b exp=aaaa/1", Result, Out_Valid);
        end
        drive(1, 1, 0, 1, 0, 0, 0, 3'd1, 32'd0, 32'h40, 3'd0);
        tick();
        vectors++;
        if (Result !== 16'hCAFE) begin miscompares++; $display("FAIL midpush_hi got=%h exp=cafe", Result); end
    endtask

    task automatic test_bubble_priority();
        drive(0, 0, 1, 1, 0, 0, 0, 3'd4, 32'h0000_7777, 32'h20, 3'd0);
        #1;
        vectors++;
        if (Stall !== 1'b0) begin miscompares++; $display("FAIL bubble_stall got=%b exp=0", Stall); end
        tick();
        vectors++;
        if (Out_Valid !== 1'b0 || WB_Out !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_valid got=%b%b exp=00", Out_Valid, WB_Out);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'h20, 3'd0);
        tick();
        vectors++;
        if (Result !== model_mem[12'h020]) begin
            miscompares++;
            $display("FAIL bubble_nowrite got=%h exp=%h", Result, model_mem[12'h020]);
        end
        drive(1, 1, 1, 1, 0, 1, 1, 3'd2, 32'hDEAD_F00D, 32'h100, 3'b111);
        model_push(12'h100, 32'hDEAD_F00D);
        #1;
        vectors++;
        if (Stall !== 1'b1) begin miscompares++; $display("FAIL prio_stall1 got=%b exp=1", Stall); end
        tick();
        vectors++;
        if (Stall !== 1'b0 || Out_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_stall2 got=%b%b exp=00", Stall, Out_Valid);
        end
        tick();
        vectors++;
        if (Out_Valid !== 1'b1 || WB_Out !== 1'b1 || WB_Address_Out !== 3'd2) begin
            miscompares++;
            $display("FAIL prio_retire got=%b%b%0d exp=112", Out_Valid, WB_Out, WB_Address_Out);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'hFF, 3'd0);
        tick();
        vectors++;
        if (Result !== 16'hF00D) begin miscompares++; $display("FAIL prio_lo got=%h exp=f00d", Result); end
    endtask

    task automatic test_back_to_back();
        // Push, pop and load with no idle cycles between them.
        drive(1, 0, 1, 0, 0, 1, 0, 3'd0, 32'h0BAD_CAFE, 32'h200, 3'd0);
        model_push(12'h200, 32'h0BAD_CAFE);
        tick();
        tick();
        drive(1, 1, 0, 1, 1, 1, 0, 3'd6, 32'd0, 32'h1FF, 3'd0);
        #1;
        vectors++;
        if (Stall !== 1'b1 || Out_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept got=%b%b exp=11", Stall, Out_Valid);
        end
        tick();
        tick();
        exp_pc = model_pop(12'h1FF);
        drive(1, 1, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'h200, 3'd0);
        #1;
        vectors++;
        if (PC_From_Stack !== exp_pc || WB_Address_Out !== 3'd6 || Stall !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pop got=%h/%0d/%b exp=%h/6/0", PC_From_Stack, WB_Address_Out, Stall, exp_pc);
        end
        tick();
        vectors++;
        if (Result !== 16'h0BAD || Out_Valid !== 1'b1 || PC_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_load got=%h/%b/%b exp=0bad/1/0", Result, Out_Valid, PC_Valid);
        end
    endtask

    task automatic test_random();
        logic [11:0] pool [8];
        logic [11:0] a, ap1;
        logic [31:0] addr, d;
        logic        wb, jw, r1, r2, r3;
        logic [2:0]  wba, fl;
        int          op;
        pool = '{12'h000, 12'h001, 12'h010, 12'h7FF, 12'h800, 12'hABC, 12'hFFE, 12'hFFF};
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                ap1 = pool[i] + 12'(k);
                d = $urandom();
                drive(1, 0, 1, 0, 0, 0, 0, 3'd0, d, {20'd0, ap1}, 3'd0);
                model_mem[ap1] = d[15:0];
                tick();
            end
        end
        for (int i = 0; i < 400; i++) begin
            op   = int'($urandom_range(0, 7));
            a    = pool[$urandom_range(0, 7)];
            addr = ($urandom() & 32'hFFFF_F000) | {20'd0, a};
            d    = $urandom();
            wb   = 1'($urandom_range(0, 1));
            jw   = 1'($urandom_range(0, 1));
            r1   = 1'($urandom_range(0, 1));
            r2   = 1'($urandom_range(0, 1));
            r3   = 1'($urandom_range(0, 1));
            wba  = 3'($urandom_range(0, 7));
            fl   = 3'($urandom_range(0, 7));
            case (op)
                0: drive(0, r1, r2, wb, jw, r3, r1, wba, d, addr, fl);
                1: drive(1, 0, 0, wb, jw, r1, r2, wba, d, addr, fl);
                2: drive(1, r1, 1, wb, jw, 0, 0, wba, d, addr, fl);
                3: drive(1, 1, 0, wb, jw, 0, 0, wba, d, addr, fl);
                4: drive(1, r1, 1, wb, jw, 0, 1, wba, d, addr, fl);
                5: drive(1, 1, 0, wb, jw, 0, 1, wba, d, addr, fl);
                6: drive(1, r1, 1, wb, jw, 1, r2, wba, d, addr, fl);
                default: drive(1, 1, 0, wb, jw, 1, r2, wba, d, addr, fl);
            endcase
            #1;
            vectors++;
            if (Stall !== (op >= 6)) begin
                miscompares++;
                $display("FAIL rnd_stall i=%0d op=%0d got=%b exp=%b", i, op, Stall, op >= 6);
            end
            if (op >= 6) begin
                tick();
                vectors++;
                if (Out_Valid !== 1'b0 || Stall !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_2cyc_bubble i=%0d got=%b%b exp=00", i, Out_Valid, Stall);
                end
            end
            case (op)
                2:       model_mem[a] = d[15:0];
                4:       model_mem[a] = {13'd0, fl};
                5:       exp_flags = model_mem[a][2:0];
                6:       model_push(a, d);
                7:       exp_pc = model_pop(a);
                default: ;
            endcase
            tick();
            vectors++;
            if (op == 0) begin
                if (Out_Valid !== 1'b0 || WB_Out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_bubble i=%0d got=%b%b exp=00", i, Out_Valid, WB_Out);
                end
            end else if ({Out_Valid, WB_Out, WB_Address_Out, JWSP_Out} !== {1'b1, wb, wba, jw}) begin
                miscompares++;
                $display("FAIL rnd_fields i=%0d op=%0d got=%b%b%0d%b exp=1%b%0d%b", i, op, Out_Valid,
                         WB_Out, WB_Address_Out, JWSP_Out, wb, wba, jw);
            end
            vectors++;
            if ((op == 1 && Result !== d[15:0]) || ((op == 3 || op == 5) && Result !== model_mem[a])) begin
                miscompares++;
                $display("FAIL rnd_result i=%0d op=%0d got=%h", i, op, Result);
            end
            vectors++;
            if ({Flags_Valid, PC_Valid, Flags_From_Memory, PC_From_Stack} !==
                {op == 5, op == 7, exp_flags, exp_pc}) begin
                miscompares++;
                $display("FAIL rnd_pop i=%0d op=%0d got=%b%b/%b/%h exp=%b%b/%b/%h", i, op, Flags_Valid,
                         PC_Valid, Flags_From_Memory, PC_From_Stack, op == 5, op == 7, exp_flags, exp_pc);
            end
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_pc_stack();
        test_flags();
        test_wrap();
        test_reset_mid_push();
        test_bubble_priority();
        test_back_to_back();
        test_random();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits directly downstream of the execution unit and consumes the EX/MEM buffer fields.
- Owns the 16-bit-wide data/stack memory. Performs loads, stores, flag push/pop and 32-bit PC push/pop. A 32-bit PC is split into two 16-bit words, so PC push/pop takes two cycles and stalls upstream for one.
- Produces registered MEM/WB fields: write-back data, popped flags and popped PC.

Parameters:
ADDR_WIDTH, 12, word-address width; memory depth is 2**ADDR_WIDTH words
DATA_WIDTH, 16, memory word width (fixed at 16; other values unsupported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
In_Valid  in  1  EX/MEM entry holds a real instruction (0 = bubble)
MR  in  1  memory read
MW  in  1  memory write
WB  in  1  register write-back enable
JWSP  in  1  jump-with-stack (RET/RTI path)
Stack_PC  in  1  operation transfers a 32-bit PC
Stack_Flags  in  1  operation transfers flags
WB_Address  in  3  destination register
Data  in  32  EX result / store data / PC to push
Address  in  32  memory address; only [ADDR_WIDTH-1:0] is used
Final_Flags  in  3  NF|CF|ZF from EX
Stall  out  1  combinational; hold EX/MEM and earlier stages this cycle
Out_Valid  out  1  MEM/WB entry valid
WB_Out  out  1  registered WB (forced 0 when entry invalid)
WB_Address_Out  out  3  registered WB_Address
JWSP_Out  out  1  registered JWSP
Result  out  16  write-back data
Flags_From_Memory  out  3  popped NF|CF|ZF
Flags_Valid  out  1  1-cycle pulse: Flags_From_Memory is new
PC_From_Stack  out  32  popped PC
PC_Valid  out  1  1-cycle pulse: PC_From_Stack is new

Behaviour:
- Memory: synchronous write. Reads are combinational and captured into output registers. Memory contents are not reset.
- A = Address[ADDR_WIDTH-1:0]. A+1 and A-1 wrap modulo 2**ADDR_WIDTH.
- Operation decode (only when In_Valid=1):
  - MW has priority over MR.
  - Stack_PC has priority over Stack_Flags.
  - In_Valid=0: no memory access, Out_Valid=0.
- States: IDLE, PUSH2, POP2.
- IDLE, plain store (MW, no stack bits): mem[A] <= Data[15:0]. Stays in IDLE.
- IDLE, flag push (MW & Stack_Flags): mem[A] <= {13'b0, Final_Flags}.
- IDLE, plain load (MR, no stack bits): Result <= mem[A] at the edge; latency 1.
- IDLE, flag pop (MR & Stack_Flags):
  - Flags_From_Memory <= mem[A][2:0], Flags_Valid <= 1.
  - Result <= mem[A].
- IDLE, non-memory op: Result <= Data[15:0].
- IDLE, PC push (MW & Stack_PC):
  - Stall=1; mem[A] <= Data[31:16]; go to PUSH2.
  - PUSH2 (inputs held by stall): Stall=0; mem[A-1] <= Data[15:0]; go to IDLE. Out_Valid is asserted for the entry only at the PUSH2 edge.
- IDLE, PC pop (MR & Stack_PC):
  - Stall=1; lo_hold <= mem[A]; go to POP2.
  - POP2: Stall=0; PC_From_Stack <= {mem[A+1], lo_hold}; PC_Valid <= 1; go to IDLE.
- Stack word order: push writes hi at A and lo at A-1. Pop with A = old SP-1 reads lo at A and hi at A+1.
- Stall is never asserted in PUSH2/POP2. Stall is asserted only in IDLE for a valid PC op.
- Registered fields (Out_Valid, WB_Out, WB_Address_Out, JWSP_Out):
  - Update once per accepted instruction: on the IDLE edge for 1-cycle ops, on the PUSH2/POP2 edge for 2-cycle ops.
  - During the IDLE cycle of a 2-cycle op, Out_Valid <= 0 (bubble).
- Flags_Valid and PC_Valid are 1-cycle pulses. Flags_From_Memory and PC_From_Stack hold their value until the next pop.
- Reset (asynchronous, any state including mid PUSH2/POP2):
  - State returns to IDLE.
  - All outputs are 0; lo_hold is 0; Stall is 0.
  - A push interrupted after its first write leaves only the hi word in memory. No further write occurs.
- Back-to-back: a new op is accepted in the IDLE cycle immediately after PUSH2/POP2; no dead cycle.

Test Plan:
1. Store Data=0x0000_BEEF at Address=0x20, then load 0x20 with WB=1, WB_Address=3 -> Result=0xBEEF, WB_Out=1, WB_Address_Out=3, Out_Valid=1 one cycle after the load.
2. PC push Data=0x1234_5678, Address=0x0FFF -> Stall=1 for exactly one cycle; mem[0xFFF]=0x1234, mem[0xFFE]=0x5678. Then PC pop at Address=0x0FFE -> Stall=1 for one cycle; PC_From_Stack=0x1234_5678; PC_Valid pulses once.
3. Flag push Final_Flags=3'b101 at 0x10, then flag pop at 0x10 -> Flags_From_Memory=3'b101, Flags_Valid high for 1 cycle, mem[0x10]=0x0005.
4. Wrap-around: PC push at Address=0 -> lo word written to 0xFFF. PC pop at Address=0xFFF -> hi read from 0x000; reconstructed PC matches.
5. Assert rst in PUSH2 -> all outputs 0 immediately; mem[A-1] unchanged. The next op after reset proceeds from IDLE with no Stall carry-over.
6. Bubble and priority: In_Valid=0 with MW=1 -> no write, Out_Valid=0. MR=MW=1, Stack_PC=Stack_Flags=1 -> treated as PC push (two writes, one stall).
